// File: rtl/msf_pkg.sv
// Shared types and constants for the MSF minute-frame decoder.
package msf_pkg;

    // Sequencer states.
    typedef enum logic {
        ST_SYNC_WAIT = 1'b0,
        ST_RECEIVE   = 1'b1
    } msf_state_e;

    localparam int unsigned SEC_CNT_W = 6;

    // Second numbers of the captured regions within a frame.
    localparam int unsigned SEC_SHIFT_FIRST = 17;
    localparam int unsigned SEC_SHIFT_LAST  = 51;
    localparam int unsigned SEC_MARK_FIRST  = 52;
    localparam int unsigned SEC_MARK_LAST   = 59;
    localparam int unsigned SEC_PAR_FIRST   = 54;
    localparam int unsigned SEC_PAR_LAST    = 57;

    localparam int unsigned SHIFT_W = SEC_SHIFT_LAST - SEC_SHIFT_FIRST + 1;
    localparam int unsigned MARK_W  = SEC_MARK_LAST - SEC_MARK_FIRST + 1;
    localparam int unsigned PAR_W   = SEC_PAR_LAST - SEC_PAR_FIRST + 1;

    // Field start/end seconds of the A-bit time code.
    localparam int unsigned YEAR_FIRST       = 17;
    localparam int unsigned YEAR_LAST        = 24;
    localparam int unsigned MONTH_FIRST      = 25;
    localparam int unsigned MONTH_LAST       = 29;
    localparam int unsigned DAY_FIRST        = 30;
    localparam int unsigned DAY_LAST         = 35;
    localparam int unsigned WDAY_FIRST       = 36;
    localparam int unsigned WDAY_LAST        = 38;
    localparam int unsigned HOUR_FIRST       = 39;
    localparam int unsigned HOUR_UNITS_FIRST = 41;
    localparam int unsigned HOUR_LAST        = 44;
    localparam int unsigned MIN_FIRST        = 45;
    localparam int unsigned MIN_UNITS_FIRST  = 48;
    localparam int unsigned MIN_LAST         = 51;

    // Odd-parity groups; each is closed by B bit 54..57 in order.
    localparam int unsigned PG0_FIRST = YEAR_FIRST;
    localparam int unsigned PG0_LAST  = YEAR_LAST;
    localparam int unsigned PG1_FIRST = MONTH_FIRST;
    localparam int unsigned PG1_LAST  = DAY_LAST;
    localparam int unsigned PG2_FIRST = WDAY_FIRST;
    localparam int unsigned PG2_LAST  = WDAY_LAST;
    localparam int unsigned PG3_FIRST = HOUR_FIRST;
    localparam int unsigned PG3_LAST  = MIN_LAST;

    localparam logic [MARK_W-1:0] MSF_MARKER = 8'b0111_1110;

    // Decoded time payload handed to the digit counters.
    typedef struct packed {
        logic [1:0] hour_tens;
        logic [3:0] hour_units;
        logic [2:0] min_tens;
        logic [3:0] min_units;
    } msf_time_t;

    // Bit position of a given second inside the shift register (second 51 lands in bit 0).
    function automatic int unsigned shift_idx(input int unsigned sec);
        return SEC_SHIFT_LAST - sec;
    endfunction

endpackage

// File: rtl/msf_frame_check.sv
// Combinational frame validation: marker, odd parity groups and BCD ranges.
module msf_frame_check
    import msf_pkg::*;
(
    input  logic [SHIFT_W-1:0] shift_reg,
    input  logic [MARK_W-1:0]  marker_reg,
    input  logic [PAR_W-1:0]   parity_reg,
    output logic               frame_ok,
    output msf_time_t          fields
);

    localparam int unsigned HT_MSB  = shift_idx(HOUR_FIRST);
    localparam int unsigned HU_MSB  = shift_idx(HOUR_UNITS_FIRST);
    localparam int unsigned MT_MSB  = shift_idx(MIN_FIRST);
    localparam int unsigned MU_MSB  = shift_idx(MIN_UNITS_FIRST);

    localparam int unsigned PG0_MSB = shift_idx(PG0_FIRST);
    localparam int unsigned PG0_LSB = shift_idx(PG0_LAST);
    localparam int unsigned PG1_MSB = shift_idx(PG1_FIRST);
    localparam int unsigned PG1_LSB = shift_idx(PG1_LAST);
    localparam int unsigned PG2_MSB = shift_idx(PG2_FIRST);
    localparam int unsigned PG2_LSB = shift_idx(PG2_LAST);
    localparam int unsigned PG3_MSB = shift_idx(PG3_FIRST);
    localparam int unsigned PG3_LSB = shift_idx(PG3_LAST);

    logic [PAR_W-1:0] par_ok;
    logic             marker_ok;
    logic             hour_ok;
    logic             min_ok;

    // Extract BCD fields and evaluate every acceptance condition.
    always_comb begin
        fields            = '0;
        fields.hour_tens  = shift_reg[HT_MSB -: 2];
        fields.hour_units = shift_reg[HU_MSB -: 4];
        fields.min_tens   = shift_reg[MT_MSB -: 3];
        fields.min_units  = shift_reg[MU_MSB -: 4];

        // Parity register bit 3 holds 54B, bit 0 holds 57B.
        par_ok    = '0;
        par_ok[3] = ^{shift_reg[PG0_MSB:PG0_LSB], parity_reg[3]};
        par_ok[2] = ^{shift_reg[PG1_MSB:PG1_LSB], parity_reg[2]};
        par_ok[1] = ^{shift_reg[PG2_MSB:PG2_LSB], parity_reg[1]};
        par_ok[0] = ^{shift_reg[PG3_MSB:PG3_LSB], parity_reg[0]};

        marker_ok = (marker_reg == MSF_MARKER);

        hour_ok = (fields.hour_units <= 4'd9) &&
                  ((fields.hour_tens < 2'd2) ||
                   ((fields.hour_tens == 2'd2) && (fields.hour_units <= 4'd3)));
        min_ok  = (fields.min_tens <= 3'd5) && (fields.min_units <= 4'd9);

        frame_ok = marker_ok && (&par_ok) && hour_ok && min_ok;
    end

endmodule

// File: rtl/msf_frame_decoder.sv
// MSF minute-frame sequencer: captures per-second bits and issues a time load on a good frame.
module msf_frame_decoder
    import msf_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 60
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sec_strobe_i,
    input  logic       minute_mark_i,
    input  logic       bit_a_i,
    input  logic       bit_b_i,
    output logic       load_o,
    output logic [1:0] hour_tens_o,
    output logic [3:0] hour_units_o,
    output logic [2:0] min_tens_o,
    output logic [3:0] min_units_o,
    output logic       synced_o,
    output logic       frame_err_o
);

    localparam logic [SEC_CNT_W-1:0] LAST_SEC = SEC_CNT_W'(FRAME_LEN - 1);

    msf_state_e           state_q, state_d;
    logic [SEC_CNT_W-1:0] sec_cnt_q, sec_cnt_d;
    logic [SEC_CNT_W-1:0] sec_next;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [MARK_W-1:0]    marker_q, marker_d;
    logic [PAR_W-1:0]     parity_q, parity_d;
    msf_time_t            time_q, time_d;
    logic                 load_d;
    logic                 err_d;
    logic                 synced_d;

    logic                 frame_ok;
    msf_time_t            fields;

    msf_frame_check u_check (
        .shift_reg  (shift_q),
        .marker_reg (marker_q),
        .parity_reg (parity_q),
        .frame_ok   (frame_ok),
        .fields     (fields)
    );

    // Next-state, capture and output decode.
    always_comb begin
        state_d   = state_q;
        sec_cnt_d = sec_cnt_q;
        shift_d   = shift_q;
        marker_d  = marker_q;
        parity_d  = parity_q;
        time_d    = time_q;
        load_d    = 1'b0;
        err_d     = 1'b0;
        sec_next  = sec_cnt_q + SEC_CNT_W'(1);

        unique case (state_q)
            ST_SYNC_WAIT: begin
                if (sec_strobe_i && minute_mark_i) begin
                    state_d   = ST_RECEIVE;
                    sec_cnt_d = '0;
                end
            end
            ST_RECEIVE: begin
                if (sec_strobe_i) begin
                    if (minute_mark_i) begin
                        // Mark closes the frame and starts the next one immediately.
                        sec_cnt_d = '0;
                        if ((sec_cnt_q == LAST_SEC) && frame_ok) begin
                            load_d = 1'b1;
                            time_d = fields;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (sec_cnt_q == LAST_SEC) begin
                        // Overlong minute (e.g. leap second): drop sync.
                        err_d     = 1'b1;
                        state_d   = ST_SYNC_WAIT;
                        sec_cnt_d = '0;
                    end else begin
                        sec_cnt_d = sec_next;
                        if ((sec_next >= SEC_CNT_W'(SEC_SHIFT_FIRST)) &&
                            (sec_next <= SEC_CNT_W'(SEC_SHIFT_LAST))) begin
                            shift_d = {shift_q[SHIFT_W-2:0], bit_a_i};
                        end
                        if ((sec_next >= SEC_CNT_W'(SEC_MARK_FIRST)) &&
                            (sec_next <= SEC_CNT_W'(SEC_MARK_LAST))) begin
                            marker_d = {marker_q[MARK_W-2:0], bit_a_i};
                        end
                        if ((sec_next >= SEC_CNT_W'(SEC_PAR_FIRST)) &&
                            (sec_next <= SEC_CNT_W'(SEC_PAR_LAST))) begin
                            parity_d = {parity_q[PAR_W-2:0], bit_b_i};
                        end
                    end
                end
            end
            default: begin
                state_d   = ST_SYNC_WAIT;
                sec_cnt_d = '0;
            end
        endcase

        synced_d = (state_d == ST_RECEIVE);
    end

    // State, capture registers and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_SYNC_WAIT;
            sec_cnt_q   <= '0;
            shift_q     <= '0;
            marker_q    <= '0;
            parity_q    <= '0;
            time_q      <= '0;
            load_o      <= 1'b0;
            frame_err_o <= 1'b0;
            synced_o    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sec_cnt_q   <= sec_cnt_d;
            shift_q     <= shift_d;
            marker_q    <= marker_d;
            parity_q    <= parity_d;
            time_q      <= time_d;
            load_o      <= load_d;
            frame_err_o <= err_d;
            synced_o    <= synced_d;
        end
    end

    assign hour_tens_o  = time_q.hour_tens;
    assign hour_units_o = time_q.hour_units;
    assign min_tens_o   = time_q.min_tens;
    assign min_units_o  = time_q.min_units;

endmodule
